wide_core: RTL and testbench

WIDE_CORE -- requirements
Module: wide_core

---
 rtl/wide_core.sv | 163 ++++++++++++++++
 tb/tb_wide_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_core.sv
// Two-word-instruction accumulator core with a request/ready memory port.
// Every memory access is one idle cycle followed by a request held until mem_ready.
module wide_core #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int REG_SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_ready,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 mem_req,
    output logic                 we,
    output logic [ADDR_W-1:0]    addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic                 halted,
    output logic                 carry,
    output logic [ADDR_W-1:0]    pc_out,
    input  logic [REG_SEL_W-1:0] dbg_sel,
    output logic [DATA_W-1:0]    dbg_val
);
    localparam int NREGS = 2 ** REG_SEL_W;

    typedef enum logic [1:0] {S_FETCH0, S_FETCH1, S_DATA, S_HALT} state_t;
    typedef enum logic [2:0] {
        OP_JMP = 3'd0, OP_LOD = 3'd1, OP_STR = 3'd2, OP_ADD = 3'd3,
        OP_SUB = 3'd4, OP_JZ  = 3'd5, OP_LDI = 3'd6, OP_HLT = 3'd7
    } op_t;

    state_t                 state_q, state_d;
    op_t                    op_q;
    logic [REG_SEL_W-1:0]   rsel_q;
    logic [ADDR_W-1:0]      pc_q, k_q, addr_q;
    logic                   mem_req_q, we_q, carry_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [DATA_W-1:0]      regs_q [NREGS];

    logic                   access_done;
    logic                   issue;
    logic                   issue_we;
    logic [ADDR_W-1:0]      issue_addr;
    logic [ADDR_W-1:0]      k_in;
    logic [ADDR_W-1:0]      pc_d;
    logic [DATA_W-1:0]      r_val;
    logic [DATA_W:0]        add_res;
    logic [DATA_W:0]        sub_res;

    assign access_done = mem_req_q & mem_ready;
    assign r_val       = regs_q[rsel_q];
    assign k_in        = mem_rdata[ADDR_W-1:0];
    assign add_res     = {1'b0, r_val} + {1'b0, mem_rdata};
    assign sub_res     = {1'b0, r_val} - {1'b0, mem_rdata};

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_we   = 1'b0;
        issue_addr = '0;
        pc_d       = pc_q + ADDR_W'(2);
        if ((op_q == OP_JMP) || ((op_q == OP_JZ) && (r_val == '0))) begin
            pc_d = k_in;
        end

        if (state_q != S_HALT && !mem_req_q) begin
            issue = 1'b1;
        end

        unique case (state_q)
            S_FETCH0: begin
                issue_addr = pc_q;
                if (access_done) state_d = S_FETCH1;
            end
            S_FETCH1: begin
                issue_addr = pc_q + ADDR_W'(1);
                if (access_done) begin
                    unique case (op_q)
                        OP_LOD, OP_STR, OP_ADD, OP_SUB: state_d = S_DATA;
                        OP_HLT:                         state_d = S_HALT;
                        default:                        state_d = S_FETCH0;
                    endcase
                end
            end
            S_DATA: begin
                issue_addr = k_q;
                issue_we   = (op_q == OP_STR);
                if (access_done) state_d = S_FETCH0;
            end
            default: state_d = S_HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH0;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_JMP;
            rsel_q    <= '0;
            pc_q      <= '0;
            k_q       <= '0;
            addr_q    <= '0;
            mem_req_q <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            carry_q   <= 1'b0;
            // NOTE: the register file is small and architecturally visible, so it is cleared on reset like any flop.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (issue) begin
                mem_req_q <= 1'b1;
                addr_q    <= issue_addr;
                we_q      <= issue_we;
                wdata_q   <= issue_we ? r_val : '0;
            end else if (access_done) begin
                mem_req_q <= 1'b0;
                we_q      <= 1'b0;
            end

            if (access_done) begin
                unique case (state_q)
                    S_FETCH0: begin
                        op_q   <= op_t'(mem_rdata[2:0]);
                        rsel_q <= mem_rdata[3 +: REG_SEL_W];
                    end
                    S_FETCH1: begin
                        k_q  <= k_in;
                        pc_q <= pc_d;
                        if (op_q == OP_LDI) regs_q[rsel_q] <= mem_rdata;
                    end
                    S_DATA: begin
                        unique case (op_q)
                            OP_LOD: regs_q[rsel_q] <= mem_rdata;
                            OP_ADD: begin
                                regs_q[rsel_q] <= add_res[DATA_W-1:0];
                                carry_q        <= add_res[DATA_W];
                            end
                            OP_SUB: begin
                                regs_q[rsel_q] <= sub_res[DATA_W-1:0];
                                carry_q        <= (r_val < mem_rdata);
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign we        = we_q;
    assign addr      = addr_q;
    assign mem_wdata = wdata_q;
    assign halted    = (state_q == S_HALT);
    assign carry     = carry_q;
    assign pc_out    = pc_q;
    assign dbg_val   = regs_q[dbg_sel];

endmodule

// File: tb/tb_wide_core.sv
// Scoreboarded bench for wide_core: expected bus accesses are queued by the
// stimulus and popped by an independent bus monitor; final state checked directly.
module tb_wide_core;
    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic       mem_req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] mem_wdata;
    logic       halted;
    logic       carry;
    logic [7:0] pc_out;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_val;

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_t;

    bus_t       sb_q[$];
    logic [7:0] mem [256];
    int         total = 0;
    int         bad   = 0;

    wide_core #(.DATA_W(8), .ADDR_W(8), .REG_SEL_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_req   (mem_req),
        .we        (we),
        .addr      (addr),
        .mem_wdata (mem_wdata),
        .halted    (halted),
        .carry     (carry),
        .pc_out    (pc_out),
        .dbg_sel   (dbg_sel),
        .dbg_val   (dbg_val)
    );

    always #5 clk = ~clk;

    // Read-only memory model: program and data are preloaded while in reset.
    assign mem_rdata = mem[addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_rd(input logic [7:0] a);
        sb_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
        sb_q.push_back('{we: 1'b1, addr: a, data: d});
    endtask

    // Bus monitor: an access completes on the rising edge after a negedge with req & ready.
    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if (!rst && mem_req && mem_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_access", 32'(addr), 32'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("bus_addr", 32'(addr), 32'(e.addr));
                    check("bus_we", 32'(we), 32'(e.we));
                    if (e.we) check("bus_wdata", 32'(mem_wdata), 32'(e.data));
                end
            end
        end
    end

    task automatic begin_test();
        rst       = 1'b1;
        mem_ready = 1'b1;
        dbg_sel   = 2'd0;
        sb_q.delete();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(output int cycles);
        cycles = 0;
        while (!halted && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("halted", 32'(halted), 32'd1);
    endtask

    task automatic check_reg(input string name, input logic [1:0] sel, input logic [7:0] exp);
        dbg_sel = sel;
        #1;
        check(name, 32'(dbg_val), 32'(exp));
    endtask

    task automatic wait_fetch(input logic [7:0] a);
        int n;
        n = 0;
        while (!(mem_req && addr == a) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("fetch_reached", 32'(mem_req && addr == a), 32'd1);
    endtask

    initial begin
        int  n;
        bit  found;
        rst       = 1'b1;
        mem_ready = 1'b1;
        dbg_sel   = 2'd0;

        // LDI r0,F0; ADD r0,[20]; STR r0,[21]; HLT
        begin_test();
        mem[0] = 8'h06; mem[1] = 8'hF0; mem[2] = 8'h03; mem[3] = 8'h20;
        mem[4] = 8'h02; mem[5] = 8'h21; mem[6] = 8'h07; mem[7] = 8'h00;
        mem[8'h20] = 8'h20;
        exp_rd(8'h00); exp_rd(8'h01); exp_rd(8'h02); exp_rd(8'h03); exp_rd(8'h20);
        exp_rd(8'h04); exp_rd(8'h05); exp_wr(8'h21, 8'h10); exp_rd(8'h06); exp_rd(8'h07);
        release_rst();
        run_to_halt(n);
        check("add_cycles", 32'(n), 32'd20);
        check("add_pc", 32'(pc_out), 32'h08);
        check("add_carry", 32'(carry), 32'd1);
        check_reg("add_r0", 2'd0, 8'h10);
        check("add_sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("halt_no_req", 32'(mem_req), 32'd0);
        check("halt_pc_hold", 32'(pc_out), 32'h08);

        // Asynchronous reset from a non-trivial state
        #2 rst = 1'b1;
        #1;
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_pc", 32'(pc_out), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 8'h00);

        // LDI r1,3; SUB r1,[30]; HLT  (borrow)
        begin_test();
        mem[0] = 8'h0E; mem[1] = 8'h03; mem[2] = 8'h0C; mem[3] = 8'h30;
        mem[4] = 8'h07; mem[5] = 8'h00; mem[8'h30] = 8'h05;
        exp_rd(8'h00); exp_rd(8'h01); exp_rd(8'h02); exp_rd(8'h03);
        exp_rd(8'h30); exp_rd(8'h04); exp_rd(8'h05);
        release_rst();
        @(posedge clk);
        #1;
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", 32'(addr), 32'd0);
        run_to_halt(n);
        check("sub_cycles", 32'(n + 1), 32'd14);
        check_reg("sub_r1", 2'd1, 8'hFE);
        check("sub_carry", 32'(carry), 32'd1);
        check("sub_pc", 32'(pc_out), 32'h06);
        check("sub_sb_empty", 32'(sb_q.size()), 32'd0);

        // LDI r2,0; JZ r2,40 taken, with a 3-cycle stall on the first fetch
        begin_test();
        mem[0] = 8'h16; mem[1] = 8'h00; mem[2] = 8'h15; mem[3] = 8'h40;
        mem[8'h40] = 8'h07; mem[8'h41] = 8'h00;
        exp_rd(8'h00); exp_rd(8'h01); exp_rd(8'h02); exp_rd(8'h03);
        exp_rd(8'h40); exp_rd(8'h41);
        mem_ready = 1'b0;
        release_rst();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_req", 32'(mem_req), 32'd1);
            check("stall_addr", 32'(addr), 32'd0);
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_done", 32'(mem_req), 32'd0);
        wait_fetch(8'h40);
        check("jz_taken_pc", 32'(pc_out), 32'h40);
        run_to_halt(n);
        check("jz_taken_final_pc", 32'(pc_out), 32'h42);
        check("jz_sb_empty", 32'(sb_q.size()), 32'd0);

        // LDI r2,1; JZ r2,40 not taken
        begin_test();
        mem[0] = 8'h16; mem[1] = 8'h01; mem[2] = 8'h15; mem[3] = 8'h40;
        mem[4] = 8'h07; mem[5] = 8'h00;
        exp_rd(8'h00); exp_rd(8'h01); exp_rd(8'h02); exp_rd(8'h03);
        exp_rd(8'h04); exp_rd(8'h05);
        release_rst();
        wait_fetch(8'h04);
        check("jz_nt_pc", 32'(pc_out), 32'h04);
        run_to_halt(n);
        check_reg("jz_nt_r2", 2'd2, 8'h01);
        check("jz_nt_sb_empty", 32'(sb_q.size()), 32'd0);

        // JMP FF; HLT at FF with word1 wrapping to 00
        begin_test();
        mem[0] = 8'h00; mem[1] = 8'hFF; mem[8'hFF] = 8'h07;
        exp_rd(8'h00); exp_rd(8'h01); exp_rd(8'hFF); exp_rd(8'h00);
        release_rst();
        run_to_halt(n);
        check("wrap_pc", 32'(pc_out), 32'h01);
        check("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset while a STR data access is pending
        begin_test();
        mem[0] = 8'h06; mem[1] = 8'h55; mem[2] = 8'h02; mem[3] = 8'h40;
        exp_rd(8'h00); exp_rd(8'h01); exp_rd(8'h02); exp_rd(8'h03);
        release_rst();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (mem_req && we) found = 1'b1;
        end
        check("str_pending_seen", 32'(found), 32'd1);
        mem_ready = 1'b0;
        check("str_addr", 32'(addr), 32'h40);
        check("str_wdata", 32'(mem_wdata), 32'h55);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_pc", 32'(pc_out), 32'd0);
        check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
        check("mid_rst_sb_empty", 32'(sb_q.size()), 32'd0);
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
